// File: rtl/display_sequencer.sv
// Two-digit octal display sequencer.
// Holds a 4-bit value that is either loaded from switches, counted up or down
// at a slow step rate, or frozen, selected by a button-driven mode FSM. The
// value is exported as a one-hot code to an external octal decoder, and the
// two returned segment patterns are time-multiplexed onto one segment bus.
module display_sequencer #(
  parameter int STEP_DIV    = 50000000,
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        btn_mode,
  input  logic [6:0]  seg_lo,
  input  logic [6:0]  seg_hi,
  output logic [15:0] onehot,
  output logic [6:0]  seg,
  output logic [1:0]  an,
  output logic [1:0]  mode,
  output logic [3:0]  value
);

  localparam int STEP_W = $clog2(STEP_DIV);
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(STEP_DIV - 1);
  localparam logic [REF_W-1:0]  REF_MAX  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2,
    HOLD      = 2'd3
  } mode_t;

  mode_t              r_mode;
  mode_t              w_mode_nxt;
  logic               r_sync0;
  logic               r_sync1;
  logic               r_sync_d;
  logic [1:0]         r_vld;
  logic               r_armed;
  logic               w_adv;
  logic [STEP_W-1:0]  r_step;
  logic [STEP_W-1:0]  w_step_nxt;
  logic               w_auto;
  logic               w_tick;
  logic [3:0]         r_value;
  logic [3:0]         w_value_nxt;
  logic [REF_W-1:0]   r_ref;
  logic               r_sel;
  logic [6:0]         r_seg;
  logic [1:0]         r_an;

  // Button synchronizer and rising-edge detector. r_vld marks when r_sync1
  // holds a real sample (not the reset value); the detector is only armed once
  // such a real sample has been low, so a button held through reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0  <= 1'b0;
      r_sync1  <= 1'b0;
      r_sync_d <= 1'b0;
      r_vld    <= 2'b00;
      r_armed  <= 1'b0;
    end else begin
      r_sync0  <= btn_mode;
      r_sync1  <= r_sync0;
      r_sync_d <= r_sync1;
      r_vld    <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync1) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_adv  = r_sync1 && !r_sync_d && r_armed;
  assign w_auto = (r_mode == AUTO_UP) || (r_mode == AUTO_DOWN);
  assign w_tick = w_auto && (r_step == STEP_MAX);

  // Mode, step counter and value registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MANUAL;
      r_step  <= '0;
      r_value <= 4'd0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_step  <= w_step_nxt;
      r_value <= w_value_nxt;
    end
  end

  // Next-state logic: a mode advance always wins over a coincident step tick,
  // and clears the step counter so a new AUTO state waits a full period.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_value_nxt = r_value;
    w_step_nxt  = '0;
    case (r_mode)
      MANUAL: begin
        w_value_nxt = sw;
        if (w_adv) w_mode_nxt = AUTO_UP;
      end
      AUTO_UP: begin
        if (w_adv) begin
          w_mode_nxt = AUTO_DOWN;
        end else if (w_tick) begin
          w_value_nxt = r_value + 4'd1;
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end
      AUTO_DOWN: begin
        if (w_adv) begin
          w_mode_nxt = HOLD;
        end else if (w_tick) begin
          w_value_nxt = r_value - 4'd1;
        end else begin
          w_step_nxt = r_step + STEP_W'(1);
        end
      end
      HOLD: begin
        if (w_adv) w_mode_nxt = MANUAL;
      end
      default: begin
        w_mode_nxt = MANUAL;
      end
    endcase
  end

  // Free-running refresh counter toggling the digit select; mode-independent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref <= '0;
      r_sel <= 1'b0;
    end else if (r_ref == REF_MAX) begin
      r_ref <= '0;
      r_sel <= ~r_sel;
    end else begin
      r_ref <= r_ref + REF_W'(1);
    end
  end

  // Registered digit enables and shared segment bus; both digits off in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 2'b11;
      r_seg <= 7'h7F;
    end else if (r_sel) begin
      r_an  <= 2'b01;
      r_seg <= seg_hi;
    end else begin
      r_an  <= 2'b10;
      r_seg <= seg_lo;
    end
  end

  assign onehot = 16'd1 << r_value;
  assign seg    = r_seg;
  assign an     = r_an;
  assign mode   = r_mode;
  assign value  = r_value;

endmodule
